// File: rtl/bus_serial_tx_pkg.sv
// Shared encodings for the bus serial transmitter: FSM states and status bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_serial_tx_pkg;

  // Transmit FSM encoding; PARITY is only reachable when the parity build option is on
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bit positions inside the status byte read back over DB
  localparam int STAT_FULL = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVF  = 2;

  // Assemble the status byte; unused upper bits read as zero
  function automatic logic [7:0] status_byte(input logic ovf, input logic busy, input logic full);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_FULL] = full;
    s[STAT_BUSY] = busy;
    s[STAT_OVF]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/bus_tx_fifo.sv
// Small synchronous FIFO holding CPU bytes until the serializer takes them.
// Latency: a push is visible at pop_dat/empty right after the pushing edge.
// Backpressure: push ignored when full unless a pop happens on the same edge.
module bus_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the simultaneous push lands in
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_serial_tx.sv
// CPU-bus mapped 8N1 serial transmitter; define BUS_SERIAL_TX_PARITY_EN for an even-parity bit.
// Latency: write at edge N, TX start bit begins after edge N+1; frame is 10 (11) * DIVISOR clocks.
// Backpressure: none toward the CPU; writes to a full FIFO are dropped and flagged sticky OVF, IRQB low while room.
module bus_serial_tx
  import bus_serial_tx_pkg::*;
#(
  parameter int DIVISOR = 16,
  parameter int DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       CLRB,
  inout  wire  [7:0] DB,
  input  logic       CSB,
  input  logic       RWB,
  output logic       TX,
  output logic       IRQB
);

  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  tx_state_e            state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 ovf_q, ovf_d;
`ifdef BUS_SERIAL_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic                 wr_en, rd_en;
  logic                 div_wrap;
  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [7:0]           fifo_dat;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 busy;
  logic [7:0]           status;

  assign wr_en    = ~CSB & ~RWB;
  assign rd_en    = ~CSB &  RWB;
  assign div_wrap = (div_q == DIV_LAST);

  // Head is taken either from idle or at the end of a stop bit so frames chain without a gap
  assign fifo_pop  = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & div_wrap));
  assign fifo_push = wr_en & (~fifo_full | fifo_pop);

  bus_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (CLRB),
    .push     (fifo_push),
    .push_dat (DB),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign busy   = (state_q != ST_IDLE) | (fifo_count != '0);
  assign status = status_byte(ovf_q, busy, fifo_full);

  // Bus is only driven during a status read; everything else leaves it floating
  assign DB = rd_en ? status : 8'hzz;

  // Interrupt also held inactive while reset is applied
  assign IRQB = fifo_full | ~CLRB;

  // FSM state register
  always_ff @(posedge CLK or negedge CLRB) begin
    if (!CLRB) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: each non-idle state holds for one full divider period
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_START;
      ST_START: if (div_wrap) state_d = ST_DATA;
      ST_DATA: begin
        if (div_wrap && bit_q == 3'd7) begin
`ifdef BUS_SERIAL_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef BUS_SERIAL_TX_PARITY_EN
      ST_PARITY: if (div_wrap) state_d = ST_STOP;
`endif
      ST_STOP:  if (div_wrap) state_d = fifo_empty ? ST_IDLE : ST_START;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: line level per state
  always_comb begin
    TX = 1'b1;
    case (state_q)
      ST_START:  TX = 1'b0;
      ST_DATA:   TX = shift_q[0];
`ifdef BUS_SERIAL_TX_PARITY_EN
      ST_PARITY: TX = par_q;
`endif
      default:   TX = 1'b1;
    endcase
  end

  // Datapath next-state: bit divider, bit counter, shifter, sticky overflow
  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ovf_d   = ovf_q;
`ifdef BUS_SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q == ST_IDLE || div_wrap) div_d = '0;
    else                                div_d = div_q + DIV_ONE;

    if (state_q == ST_START && div_wrap)     bit_d = 3'd0;
    else if (state_q == ST_DATA && div_wrap) bit_d = bit_q + 3'd1;

    if (fifo_pop) begin
      shift_d = fifo_dat;
`ifdef BUS_SERIAL_TX_PARITY_EN
      par_d   = ^fifo_dat;
`endif
    end else if (state_q == ST_DATA && div_wrap) begin
      shift_d = shift_q >> 1;
    end

    // A read and a write cannot coincide, so clear-on-read never races set-on-overflow
    if (rd_en)                       ovf_d = 1'b0;
    else if (wr_en && !fifo_push)    ovf_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge CLRB) begin
    if (!CLRB) begin
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      ovf_q   <= 1'b0;
`ifdef BUS_SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
`ifdef BUS_SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_serial_tx.sv
// Directed bench for bus_serial_tx at DIVISOR=4, DEPTH=4.
// Works with and without BUS_SERIAL_TX_PARITY_EN.
// Frames are described as {stop, data[7:0], start} plus the even-parity bit.
module tb_bus_serial_tx;

  localparam int D = 4;
`ifdef BUS_SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       CLK = 1'b0;
  logic       CLRB;
  logic       CSB;
  logic       RWB;
  logic       TX;
  logic       IRQB;
  wire  [7:0] DB;
  logic [7:0] db_drv;
  logic       db_oe;

  int n_chk;
  int n_err;

  typedef struct {
    logic [7:0] dat;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t tbl [5];

  assign DB = db_oe ? db_drv : 8'hzz;

  always #5 CLK = ~CLK;

  bus_serial_tx #(
    .DIVISOR (D),
    .DEPTH   (4)
  ) dut (
    .CLK  (CLK),
    .CLRB (CLRB),
    .DB   (DB),
    .CSB  (CSB),
    .RWB  (RWB),
    .TX   (TX),
    .IRQB (IRQB)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One write cycle; called #1 after an edge, returns #1 after the pushing edge
  task automatic wr(input logic [7:0] d);
    db_drv = d;
    db_oe  = 1'b1;
    RWB    = 1'b0;
    CSB    = 1'b0;
    @(posedge CLK);
    #1;
    CSB    = 1'b1;
    RWB    = 1'b1;
    db_oe  = 1'b0;
  endtask

  // Status read that does not span a clock edge
  task automatic rd(input string nm, input logic [7:0] exp);
    db_oe = 1'b0;
    RWB   = 1'b1;
    CSB   = 1'b0;
    #1;
    chk(nm, DB, exp);
    CSB   = 1'b1;
  endtask

  // Expected line bits in time order; bit 10 is only looked at in the parity build
  function automatic logic [10:0] fexp(input logic [9:0] f, input logic p);
    logic [10:0] r;
`ifdef BUS_SERIAL_TX_PARITY_EN
    r = {1'b1, p, f[8:0]};
`else
    r = {1'b0, f};
    r[10] = p;
`endif
    return r;
  endfunction

  // Called #1 after the edge that starts a frame; returns #1 after the edge that ends it
  task automatic check_frame(input string nm, input logic [10:0] e, input logic [7:0] st_last);
    for (int k = 0; k < NB; k++) begin
      repeat (D/2) @(posedge CLK);
      #1;
      chk($sformatf("%s bit%0d", nm, k), TX, e[k]);
      if (k == NB-1) begin
        repeat (D - D/2 - 1) @(posedge CLK);
        #1;
        rd({nm, " last-cycle status"}, st_last);
        @(posedge CLK);
        #1;
      end else begin
        repeat (D - D/2) @(posedge CLK);
        #1;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    CSB    = 1'b1;
    RWB    = 1'b1;
    db_oe  = 1'b0;
    db_drv = 8'h00;
    CLRB   = 1'b0;

    tbl[0] = '{dat: 8'hA5, frame: 10'h34A, par: 1'b0};
    tbl[1] = '{dat: 8'h00, frame: 10'h200, par: 1'b0};
    tbl[2] = '{dat: 8'hFF, frame: 10'h3FE, par: 1'b0};
    tbl[3] = '{dat: 8'h3C, frame: 10'h278, par: 1'b0};
    tbl[4] = '{dat: 8'h07, frame: 10'h20E, par: 1'b1};

    // Reset state
    #12;
    chk("reset TX", TX, 1);
    chk("reset IRQB", IRQB, 1);
    rd("reset status", 8'h00);
    @(posedge CLK);
    #1;
    CLRB = 1'b1;
    #1;
    chk("IRQB after release", IRQB, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("idle TX", TX, 1);

    // Single-byte frames from the table
    for (int i = 0; i < 5; i++) begin
      wr(tbl[i].dat);
      chk($sformatf("v%0d TX before pop", i), TX, 1);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d TX start", i), TX, 0);
      check_frame($sformatf("v%0d", i), fexp(tbl[i].frame, tbl[i].par), 8'h02);
      rd($sformatf("v%0d end status", i), 8'h00);
      chk($sformatf("v%0d TX idle", i), TX, 1);
      repeat (3) @(posedge CLK);
      #1;
    end

    // Back-to-back: second start bit immediately follows first stop bit
    wr(8'h01);
    wr(8'h80);
    chk("b2b first start", TX, 0);
    check_frame("b2b 01", fexp(10'h202, 1'b1), 8'h02);
    chk("b2b no gap", TX, 0);
    check_frame("b2b 80", fexp(10'h300, 1'b1), 8'h02);
    rd("b2b end status", 8'h00);

    // Overflow while the first frame holds the line
    repeat (2) @(posedge CLK);
    #1;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    wr(8'h44);
    wr(8'h55);
    rd("ovf full status", 8'h03);
    chk("ovf IRQB full", IRQB, 1);
    wr(8'h66);
    rd("ovf sticky status", 8'h07);
    db_oe = 1'b0;
    RWB   = 1'b1;
    CSB   = 1'b0;
    @(posedge CLK);
    #1;
    chk("ovf cleared by read", DB, 8'h03);
    CSB = 1'b1;
    repeat (NB*D - 5) @(posedge CLK);
    #1;
    chk("ovf frame2 start", TX, 0);
    check_frame("ovf 22", fexp(10'h244, 1'b0), 8'h02);
    check_frame("ovf 33", fexp(10'h266, 1'b0), 8'h02);
    check_frame("ovf 44", fexp(10'h288, 1'b0), 8'h02);
    check_frame("ovf 55", fexp(10'h2AA, 1'b0), 8'h02);
    rd("ovf end status", 8'h00);
    begin
      int lows;
      lows = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge CLK);
        #1;
        if (TX == 1'b0) lows++;
      end
      chk("ovf dropped byte absent", lows, 0);
    end

    // Full FIFO, write lands on the stop-wrap pop edge
    wr(8'hA1);
    wr(8'hB2);
    wr(8'hC3);
    wr(8'hD4);
    wr(8'hE5);
    rd("fullpop filled", 8'h03);
    repeat (NB*D - 4) @(posedge CLK);
    #1;
    wr(8'hF6);
    chk("fullpop next start", TX, 0);
    rd("fullpop accepted", 8'h03);
    check_frame("fullpop B2", fexp(10'h364, 1'b0), 8'h03);
    check_frame("fullpop C3", fexp(10'h386, 1'b0), 8'h02);
    check_frame("fullpop D4", fexp(10'h3A8, 1'b0), 8'h02);
    check_frame("fullpop E5", fexp(10'h3CA, 1'b1), 8'h02);
    check_frame("fullpop F6", fexp(10'h3EC, 1'b0), 8'h02);
    rd("fullpop end status", 8'h00);

    // Reset in the middle of a frame
    repeat (2) @(posedge CLK);
    #1;
    wr(8'hA5);
    repeat (12) @(posedge CLK);
    #2;
    CLRB = 1'b0;
    #1;
    chk("midrst TX", TX, 1);
    chk("midrst IRQB", IRQB, 1);
    rd("midrst status in reset", 8'h00);
    @(posedge CLK);
    #1;
    CLRB = 1'b1;
    #1;
    chk("midrst IRQB release", IRQB, 0);
    rd("midrst status release", 8'h00);
    begin
      int lows;
      lows = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge CLK);
        #1;
        if (TX == 1'b0) lows++;
      end
      chk("midrst nothing sent", lows, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
